// File: rtl/rle_vga_pkg.sv
// Shared types and constants for the RLE VGA pipeline front end.
// Holds the QSPI reader state encoding and the flash command opcode.
package rle_vga_pkg;

  localparam int ADDR_W = 24;
  localparam int WORD_W = 16;

  localparam logic [7:0] CMD_QUAD_READ = 8'h6B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA
  } qspi_state_t;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with a flush input and full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage is reset only because it is tiny and the head must read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/qspi_stream_reader.sv
// Streams 16-bit words from QSPI flash using Fast Read Quad Output (0x6B).
// SPI clock runs at clk/2 and is parked low whenever the output FIFO has no room.
module qspi_stream_reader
  import rle_vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CS_GAP     = 4,
  parameter int DUMMY_CLKS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  output logic              busy,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              spi_cs,
  output logic              spi_clk,
  output logic              spi_mosi,
  output logic              spi_d_oe,
  input  logic [3:0]        spi_miso
);

  localparam int CNT_W = 8;

  qspi_state_t       state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              ph, ph_next;
  logic [31:0]       sh, sh_next;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [11:0]       word, word_next;
  logic [1:0]        nib, nib_next;
  logic              cs_next, clk_next, mosi_next, oe_next, busy_next;
  logic              push, flush, full, empty;

  stream_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data ({word, spi_miso}),
    .pop       (out_valid && out_ready),
    .pop_data  (out_data),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid = !empty;

  // NOTE: every output pin is a flop fed from this block, so defaults hold the current values.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ph_next    = ph;
    sh_next    = sh;
    addr_next  = addr;
    word_next  = word;
    nib_next   = nib;
    cs_next    = spi_cs;
    clk_next   = spi_clk;
    mosi_next  = spi_mosi;
    oe_next    = spi_d_oe;
    busy_next  = busy;
    push       = 1'b0;
    flush      = 1'b0;

    if (start) begin
      state_next = S_GAP;
      cnt_next   = '0;
      ph_next    = 1'b0;
      addr_next  = start_addr;
      nib_next   = '0;
      cs_next    = 1'b1;
      clk_next   = 1'b0;
      mosi_next  = 1'b0;
      oe_next    = 1'b0;
      busy_next  = 1'b1;
      flush      = 1'b1;
    end else if (stop) begin
      state_next = S_IDLE;
      ph_next    = 1'b0;
      nib_next   = '0;
      cs_next    = 1'b1;
      clk_next   = 1'b0;
      mosi_next  = 1'b0;
      oe_next    = 1'b0;
      busy_next  = 1'b0;
      flush      = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_GAP: begin
          if (cnt == CNT_W'(CS_GAP - 1)) begin
            state_next = S_CMD;
            cnt_next   = '0;
            ph_next    = 1'b0;
            sh_next    = {CMD_QUAD_READ, addr};
            cs_next    = 1'b0;
            clk_next   = 1'b0;
            oe_next    = 1'b1;
            mosi_next  = CMD_QUAD_READ[7];
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        // Command and address share one 32-bit shifter; the state only tracks which part is on the wire.
        S_CMD, S_ADDR: begin
          if (!ph) begin
            clk_next = 1'b1;
            ph_next  = 1'b1;
          end else begin
            clk_next  = 1'b0;
            ph_next   = 1'b0;
            cnt_next  = cnt + 1'b1;
            sh_next   = {sh[30:0], 1'b0};
            mosi_next = sh[30];
            if (cnt == CNT_W'(7)) state_next = S_ADDR;
            if (cnt == CNT_W'(31)) begin
              state_next = S_DUMMY;
              cnt_next   = '0;
              oe_next    = 1'b0;
              mosi_next  = 1'b0;
            end
          end
        end
        S_DUMMY: begin
          if (!ph) begin
            clk_next = 1'b1;
            ph_next  = 1'b1;
          end else begin
            clk_next = 1'b0;
            ph_next  = 1'b0;
            cnt_next = cnt + 1'b1;
            if (cnt == CNT_W'(DUMMY_CLKS - 1)) begin
              state_next = S_DATA;
              nib_next   = '0;
            end
          end
        end
        S_DATA: begin
          // A new word only starts when a slot is free, so a completed word always fits.
          if (!ph) begin
            if (nib != 2'd0 || !full) begin
              clk_next = 1'b1;
              ph_next  = 1'b1;
            end
          end else begin
            clk_next  = 1'b0;
            ph_next   = 1'b0;
            nib_next  = nib + 1'b1;
            word_next = {word[7:0], spi_miso};
            if (nib == 2'd3) push = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ph       <= 1'b0;
      sh       <= '0;
      addr     <= '0;
      word     <= '0;
      nib      <= '0;
      spi_cs   <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_d_oe <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      ph       <= ph_next;
      sh       <= sh_next;
      addr     <= addr_next;
      word     <= word_next;
      nib      <= nib_next;
      spi_cs   <= cs_next;
      spi_clk  <= clk_next;
      spi_mosi <= mosi_next;
      spi_d_oe <= oe_next;
      busy     <= busy_next;
    end
  end

endmodule

// File: tb/tb_qspi_stream_reader.sv
// Directed bench for qspi_stream_reader with a behavioural quad-output flash model.
// Flash byte at address a is 0x12 + 0x22*a[7:0], so offsets 0..3 read 12 34 56 78.
module tb_qspi_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic [23:0] start_addr = '0;
  logic        stop = 1'b0;
  logic        busy;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        spi_cs, spi_clk, spi_mosi, spi_d_oe;
  logic [3:0]  spi_miso = 4'h0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  qspi_stream_reader #(
    .FIFO_DEPTH (2),
    .CS_GAP     (4),
    .DUMMY_CLKS (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .stop       (stop),
    .busy       (busy),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .spi_cs     (spi_cs),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_d_oe   (spi_d_oe),
    .spi_miso   (spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] byte_fn(input logic [23:0] a);
    logic [15:0] p;
    p = 16'h22 * {8'h00, a[7:0]} + 16'h12;
    return p[7:0];
  endfunction

  // Flash model: 8 cmd + 24 addr rises on mosi, 8 dummy clocks, then one nibble per falling edge.
  int          rise_cnt = 0;
  int          fall_cnt = 0;
  int          line_err = 0;
  logic [31:0] cap = '0;

  always @(posedge spi_clk or negedge spi_clk or posedge spi_cs) begin
    logic [7:0] b;
    int j;
    if (spi_cs) begin
      rise_cnt = 0;
      fall_cnt = 0;
      line_err = 0;
      cap      = '0;
    end else if (spi_clk) begin
      rise_cnt++;
      if (rise_cnt <= 32) begin
        cap = {cap[30:0], spi_mosi};
        if (spi_d_oe !== 1'b1) line_err++;
      end else if (rise_cnt <= 40) begin
        if (spi_d_oe !== 1'b0 || spi_mosi !== 1'b0) line_err++;
      end
    end else begin
      fall_cnt++;
      if (fall_cnt >= 40) begin
        j = fall_cnt - 40;
        b = byte_fn(cap[23:0] + 24'(j / 2));
        spi_miso = (j % 2 == 0) ? b[7:4] : b[3:0];
      end
    end
  end

  task automatic issue(input logic s, input logic p, input logic [23:0] a);
    start      = s;
    stop       = p;
    start_addr = a;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic measure_gap(output int n);
    n = 0;
    while (spi_cs === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_rises(input int n, input string tag);
    int t = 0;
    while (rise_cnt < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (rise_cnt < n) begin
      checks++; errors++;
      $display("FAIL %s timeout: rises %0d, want %0d", tag, rise_cnt, n);
    end
  endtask

  task automatic wait_valid(input string tag);
    int t = 0;
    while (out_valid !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (out_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for out_valid", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({spi_cs, spi_clk, spi_mosi, spi_d_oe, out_valid, busy} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 100000", {spi_cs, spi_clk, spi_mosi, spi_d_oe, out_valid, busy});
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data got %h want 0000", out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b1, 1'b0, 24'h000100);
    while (spi_cs === 1'b1 && cyc < 40) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if ({spi_cs, busy} !== 2'b01) begin
      errors++;
      $display("FAIL pre_async_reset cs/busy got %b want 01", {spi_cs, busy});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({spi_cs, spi_clk, spi_d_oe, out_valid, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL async_reset got %b want 10000", {spi_cs, spi_clk, spi_d_oe, out_valid, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_command();
    int gap;
    out_ready = 1'b1;
    issue(1'b1, 1'b0, 24'h000100);
    measure_gap(gap);
    checks++;
    if (gap !== 4) begin
      errors++;
      $display("FAIL cmd_cs_gap got %0d want 4", gap);
    end
    wait_rises(32, "cmd_addr");
    checks++;
    if (cap !== {8'h6B, 24'h000100}) begin
      errors++;
      $display("FAIL cmd_addr_bits got %h want 6b000100", cap);
    end
    wait_rises(40, "dummy");
    checks++;
    if (line_err !== 0) begin
      errors++;
      $display("FAIL cmd_oe_mosi got %0d bad clocks want 0", line_err);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL cmd_busy got %b want 1", busy);
    end
  endtask

  task automatic test_data_packing();
    logic [15:0] exp_w [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDE00};
    logic [15:0] got [4];
    int stamp [4];
    int k = 0;
    int t = 0;
    while (k < 4 && t < 300) begin
      @(negedge clk);
      t++;
      if (out_valid && out_ready) begin
        got[k]   = out_data;
        stamp[k] = cyc;
        k++;
      end
    end
    checks++;
    if (k !== 4) begin
      errors++;
      $display("FAIL pack_count got %0d words want 4", k);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL pack_word%0d got %h want %h", i, got[i], exp_w[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (stamp[i] - stamp[i-1] !== 8) begin
          errors++;
          $display("FAIL pack_cadence%0d got %0d cycles want 8", i, stamp[i] - stamp[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int clk_hi = 0;
    int cs_hi = 0;
    int k = 0;
    int t = 0;
    logic [15:0] exp;
    @(negedge clk);
    out_ready = 1'b0;
    issue(1'b1, 1'b0, 24'h000100);
    repeat (150) @(negedge clk);
    checks++;
    if (fall_cnt !== 48) begin
      errors++;
      $display("FAIL bp_nibbles got %0d falls want 48", fall_cnt);
    end
    checks++;
    if ({out_valid, spi_cs} !== 2'b10 || out_data !== 16'h1234) begin
      errors++;
      $display("FAIL bp_head got valid=%b cs=%b data=%h want valid=1 cs=0 data=1234", out_valid, spi_cs, out_data);
    end
    repeat (20) begin
      @(negedge clk);
      if (spi_clk !== 1'b0) clk_hi++;
      if (spi_cs !== 1'b0) cs_hi++;
    end
    checks++;
    if (clk_hi !== 0 || cs_hi !== 0) begin
      errors++;
      $display("FAIL bp_stall got spi_clk high %0d cs high %0d want 0 0", clk_hi, cs_hi);
    end
    while (k < 64 && t < 3000) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        exp = {byte_fn(24'h000100 + 24'(2 * k)), byte_fn(24'h000100 + 24'(2 * k + 1))};
        checks++;
        if (out_data !== exp) begin
          errors++;
          $display("FAIL bp_word%0d got %h want %h", k, out_data, exp);
        end
        k++;
      end
      @(negedge clk);
      t++;
    end
    if (k < 64) begin
      checks++; errors++;
      $display("FAIL bp_stream got %0d words want 64", k);
    end
  endtask

  task automatic test_restart();
    int gap;
    out_ready = 1'b0;
    issue(1'b1, 1'b0, 24'h000100);
    wait_valid("restart_fill");
    issue(1'b1, 1'b0, 24'h002000);
    checks++;
    if ({out_valid, spi_cs, spi_clk} !== 3'b010) begin
      errors++;
      $display("FAIL restart_flush got valid/cs/clk %b want 010", {out_valid, spi_cs, spi_clk});
    end
    measure_gap(gap);
    checks++;
    if (gap < 4) begin
      errors++;
      $display("FAIL restart_gap got %0d want >=4", gap);
    end
    wait_rises(32, "restart_cmd");
    checks++;
    if (cap !== {8'h6B, 24'h002000}) begin
      errors++;
      $display("FAIL restart_addr got %h want 6b002000", cap);
    end
    out_ready = 1'b1;
    wait_valid("restart_word");
    checks++;
    if (out_data !== 16'h1234) begin
      errors++;
      $display("FAIL restart_word got %h want 1234", out_data);
    end
  endtask

  task automatic test_stop();
    int gap;
    @(negedge clk);
    issue(1'b1, 1'b0, 24'h000100);
    wait_rises(33, "stop_dummy");
    issue(1'b0, 1'b1, 24'h000000);
    checks++;
    if ({spi_cs, spi_clk, spi_d_oe, out_valid, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL stop_idle got %b want 10000", {spi_cs, spi_clk, spi_d_oe, out_valid, busy});
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rise_cnt !== 0 || spi_cs !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_stays_idle got rises=%0d cs=%b busy=%b want 0 1 0", rise_cnt, spi_cs, busy);
    end
    issue(1'b1, 1'b1, 24'h000300);
    checks++;
    if ({busy, spi_cs} !== 2'b11) begin
      errors++;
      $display("FAIL collide_busy got busy/cs %b want 11", {busy, spi_cs});
    end
    measure_gap(gap);
    checks++;
    if (gap !== 4) begin
      errors++;
      $display("FAIL collide_gap got %0d want 4", gap);
    end
    wait_rises(32, "collide_cmd");
    checks++;
    if (cap !== {8'h6B, 24'h000300}) begin
      errors++;
      $display("FAIL collide_addr got %h want 6b000300", cap);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_command();
    test_data_packing();
    test_backpressure();
    test_restart();
    test_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
